// File: rtl/hazard_scoreboard_if.sv
// Hazard controller bus: ID-stage issue/operand info in, stage-control out.
interface hazard_scoreboard_if #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int LAT_W        = 2,
    parameter int FLUSH_STAGES = 3
);
    logic                    issue_RegWr;
    logic [AW-1:0]           issue_Rd;
    logic [LAT_W-1:0]        issue_lat;
    logic [AW-1:0]           Ra;
    logic [AW-1:0]           Rb;
    logic                    Ra_used;
    logic                    Rb_used;
    logic                    Redirect;
    logic                    En;
    logic                    Bubble;
    logic [FLUSH_STAGES-1:0] Flush;
    logic [NREG-1:0]         Pending;
    logic [31:0]             StallCnt;

    modport master (
        output issue_RegWr, issue_Rd, issue_lat, Ra, Rb, Ra_used, Rb_used, Redirect,
        input  En, Bubble, Flush, Pending, StallCnt
    );

    modport slave (
        input  issue_RegWr, issue_Rd, issue_lat, Ra, Rb, Ra_used, Rb_used, Redirect,
        output En, Bubble, Flush, Pending, StallCnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard controller: per-register result latency tracking,
// PC/IF_ID hold, ID_EX bubble, redirect flush and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int LAT_W        = 2,
    parameter int MAX_LAT      = 2,
    parameter int FLUSH_STAGES = 3
) (
    input  logic CLK,
    input  logic Reset,
    hazard_scoreboard_if.slave hs
);
    // Producers issued within the last HD cycles are still young enough to be
    // killed by a redirect resolved in MEM.
    localparam int HD = FLUSH_STAGES - 2;

    if (AW != $clog2(NREG)) begin : g_err_aw
        $error("hazard_scoreboard: AW must equal clog2(NREG)");
    end
    if (MAX_LAT > FLUSH_STAGES - 1) begin : g_err_flush
        $error("hazard_scoreboard: MAX_LAT exceeds FLUSH_STAGES-1");
    end
    if (MAX_LAT > (1 << LAT_W) - 1) begin : g_err_latw
        $error("hazard_scoreboard: MAX_LAT does not fit in LAT_W bits");
    end

    logic [NREG-1:0][LAT_W-1:0] cnt;
    logic [NREG-1:0]            clr_mask;
    logic [NREG-1:0]            pend_q;
    logic [31:0]                stall_q;
    logic                       hz_a, hz_b, stall, fire;

    // Hazard check against pre-update counts, so self-dependence sees the old producer.
    always_comb begin
        hz_a  = hs.Ra_used && (hs.Ra != '0) && (cnt[hs.Ra] != '0);
        hz_b  = hs.Rb_used && (hs.Rb != '0) && (cnt[hs.Rb] != '0);
        stall = (hz_a || hz_b) && !hs.Redirect;
        fire  = !stall && !hs.Redirect && hs.issue_RegWr && (hs.issue_Rd != '0);
    end

    // Reset overrides the stage controls so the pipe is held and emptied.
    assign hs.En       = !Reset && !stall;
    assign hs.Bubble   = Reset || stall || hs.Redirect;
    assign hs.Flush    = {FLUSH_STAGES{Reset || hs.Redirect}};
    assign hs.Pending  = pend_q;
    assign hs.StallCnt = stall_q;

    // Per-register countdown: flush-clear, then issue reload, then decrement.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)
                    cnt[r] <= '0;
                else if (clr_mask[r])
                    cnt[r] <= '0;
                else if (fire && hs.issue_Rd == AW'(r))
                    cnt[r] <= hs.issue_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    // Pending mirrors the count state one cycle late; x0 is never tracked.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= (r != 0) && (cnt[r] != '0);
        end
    end

    // Saturating stall-cycle counter for performance debug.
    always_ff @(posedge CLK) begin
        if (Reset)
            stall_q <= '0;
        else if (stall && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    if (HD > 0) begin : g_hist
        logic [HD-1:0]         h_vld;
        logic [HD-1:0][AW-1:0] h_rd;

        // Shift register of recent multi-cycle producers; a redirect kills them all.
        always_ff @(posedge CLK) begin
            if (Reset) begin
                h_vld <= '0;
                h_rd  <= '0;
            end else begin
                h_vld[0] <= fire && (hs.issue_lat != '0) && !hs.Redirect;
                h_rd[0]  <= hs.issue_Rd;
                for (int h = 1; h < HD; h++) begin
                    h_vld[h] <= h_vld[h-1] && !hs.Redirect;
                    h_rd[h]  <= h_rd[h-1];
                end
            end
        end

        // Flushed younger producers must not leave stale countdowns behind.
        always_comb begin
            clr_mask = '0;
            if (hs.Redirect)
                for (int h = 0; h < HD; h++)
                    if (h_vld[h])
                        clr_mask[h_rd[h]] = 1'b1;
        end
    end else begin : g_no_hist
        assign clr_mask = '0;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench: driver applies one vector per cycle and queues the
// hand-computed expectation; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if hif ();
    hazard_scoreboard dut (.CLK(clk), .Reset(rst), .hs(hif.slave));

    typedef struct {
        logic        rst, wr, rau, rbu, redir, frc;
        logic [4:0]  rd, ra, rb;
        logic [1:0]  lat;
        logic        en, bub;
        logic [2:0]  fl;
        logic [31:0] pend, sc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        en, bub;
        logic [2:0]  fl;
        logic [31:0] pend, sc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   drv_done = 0;

    task automatic add(input logic r, input logic wr, input logic [4:0] rd, input logic [1:0] lat,
                       input logic [4:0] ra, input logic rau, input logic [4:0] rb, input logic rbu,
                       input logic redir, input logic frc,
                       input logic en, input logic bub, input logic [2:0] fl,
                       input logic [31:0] pend, input logic [31:0] sc);
        vec_t v;
        v.rst = r; v.wr = wr; v.rd = rd; v.lat = lat; v.ra = ra; v.rau = rau;
        v.rb = rb; v.rbu = rbu; v.redir = redir; v.frc = frc;
        v.en = en; v.bub = bub; v.fl = fl; v.pend = pend; v.sc = sc;
        vecs.push_back(v);
    endtask

    // Driver
    initial begin
        hif.issue_RegWr = 0; hif.issue_Rd = 0; hif.issue_lat = 0;
        hif.Ra = 0; hif.Rb = 0; hif.Ra_used = 0; hif.Rb_used = 0; hif.Redirect = 0;
        //   rst wr rd lat ra rau rb rbu rdr frc | en bub fl pend sc
        add(1, 1, 3, 1, 3, 1, 0, 0, 0, 0,  0, 1, 3'b111, 32'h0, 32'd0); // c0 reset
        add(1, 1, 3, 1, 3, 1, 0, 0, 0, 0,  0, 1, 3'b111, 32'h0, 32'd0); // c1 reset
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd0); // c2 release
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd0); // c3 load x5
        add(0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 3'b000, 32'h0, 32'd0); // c4 load-use stall
        add(0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 0, 3'b000, 32'h20, 32'd1); // c5 go
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd1); // c6
        add(0, 1, 7, 2, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd1); // c7 x7 lat2
        add(0, 0, 0, 0, 0, 0, 7, 1, 0, 0,  0, 1, 3'b000, 32'h0, 32'd1); // c8 stall
        add(0, 0, 0, 0, 0, 0, 7, 1, 0, 0,  0, 1, 3'b000, 32'h80, 32'd2); // c9 stall
        add(0, 0, 0, 0, 0, 0, 7, 1, 0, 0,  1, 0, 3'b000, 32'h80, 32'd3); // c10 go
        add(0, 1, 0, 2, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c11 write x0
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c12 read x0
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c13
        add(0, 1, 9, 2, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c14 x9 lat2
        add(0, 1, 4, 1, 9, 1, 0, 0, 1, 0,  1, 1, 3'b111, 32'h0, 32'd3); // c15 redirect
        add(0, 0, 0, 0, 9, 1, 4, 1, 0, 0,  1, 0, 3'b000, 32'h200, 32'd3); // c16 x9 cleared
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c17
        add(0, 1, 6, 2, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c18 x6 lat2
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c19
        add(0, 0, 0, 0, 6, 1, 0, 0, 1, 0,  1, 1, 3'b111, 32'h40, 32'd3); // c20 hz+redirect
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h40, 32'd3); // c21
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'd3); // c22
        add(0, 1, 10, 2, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'h0, 32'd3); // c23 x10 lat2
        add(0, 1, 10, 2, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'h0, 32'd3); // c24 reissue
        add(0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 3'b000, 32'h400, 32'd3); // c25 stall
        add(0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 3'b000, 32'h400, 32'd4); // c26 stall
        add(0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 3'b000, 32'h400, 32'd5); // c27 go
        add(0, 1, 11, 2, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'h0, 32'd5); // c28 x11 lat2
        add(0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 3'b000, 32'h0, 32'd5); // c29 stall
        add(1, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 3'b111, 32'h800, 32'd6); // c30 reset mid-stall
        add(0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 3'b000, 32'h0, 32'd0); // c31 cleared
        add(0, 1, 12, 2, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 32'h0, 32'hFFFF_FFFE); // c32 preload
        add(0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1, 3'b000, 32'h0, 32'hFFFF_FFFE); // c33 stall
        add(0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1, 3'b000, 32'h1000, 32'hFFFF_FFFF); // c34 sat
        add(0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 1, 0, 3'b000, 32'h1000, 32'hFFFF_FFFF); // c35
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 32'h0, 32'hFFFF_FFFF); // c36

        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst             = vecs[i].rst;
            hif.issue_RegWr = vecs[i].wr;
            hif.issue_Rd    = vecs[i].rd;
            hif.issue_lat   = vecs[i].lat;
            hif.Ra          = vecs[i].ra;
            hif.Rb          = vecs[i].rb;
            hif.Ra_used     = vecs[i].rau;
            hif.Rb_used     = vecs[i].rbu;
            hif.Redirect    = vecs[i].redir;
            if (vecs[i].frc) begin
                force dut.stall_q = 32'hFFFF_FFFE;
                #1;
                release dut.stall_q;
            end
            e.idx = i; e.en = vecs[i].en; e.bub = vecs[i].bub; e.fl = vecs[i].fl;
            e.pend = vecs[i].pend; e.sc = vecs[i].sc;
            exp_q.push_back(e);
        end
        drv_done = 1;
    end

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (hif.En !== e.en) begin
                n_bad++; $display("FAIL v%0d En: got %b want %b", e.idx, hif.En, e.en);
            end
            if (hif.Bubble !== e.bub) begin
                n_bad++; $display("FAIL v%0d Bubble: got %b want %b", e.idx, hif.Bubble, e.bub);
            end
            if (hif.Flush !== e.fl) begin
                n_bad++; $display("FAIL v%0d Flush: got %b want %b", e.idx, hif.Flush, e.fl);
            end
            if (hif.Pending !== e.pend) begin
                n_bad++; $display("FAIL v%0d Pending: got %h want %h", e.idx, hif.Pending, e.pend);
            end
            if (hif.StallCnt !== e.sc) begin
                n_bad++; $display("FAIL v%0d StallCnt: got %h want %h", e.idx, hif.StallCnt, e.sc);
            end
        end
    end

    // Termination with bounded drain
    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        #1;
        if (!drv_done || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: done=%0d left=%0d want done=1 left=0", drv_done, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
